// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry-type codes and per-entry payload layout for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_POS_W = 4;
  localparam int unsigned ROB_SIZE  = 1 << ROB_POS_W;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_POS_W = 5;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned CNT_W     = ROB_POS_W + 1;

  typedef enum logic [TYPE_W-1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2
  } rob_type_e;

  // Busy/ready flags live outside the payload so they can be cleared in one flush.
  typedef struct packed {
    rob_type_e            kind;
    logic [REG_POS_W-1:0] rd;
    logic [DATA_W-1:0]    val;
    logic [DATA_W-1:0]    pc;
    logic                 pred_jump;
    logic                 real_jump;
    logic [DATA_W-1:0]    target;
  } rob_entry_t;

  function automatic logic is_mispredict(input rob_entry_t e);
    return (e.kind == ROB_BRANCH) && (e.real_jump != e.pred_jump);
  endfunction

  function automatic logic [DATA_W-1:0] redirect_pc(input rob_entry_t e);
    return e.real_jump ? e.target : e.pc + DATA_W'(4);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder / ALU / LSB / commit bundle of the reorder buffer; slave is the ROB side.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic                 rob_full;
  logic [ROB_POS_W-1:0] rob_nxt_pos;

  logic                 issue;
  logic [TYPE_W-1:0]    issue_type;
  logic [REG_POS_W-1:0] issue_rd;
  logic [DATA_W-1:0]    issue_pc;
  logic                 issue_pred_jump;
  logic                 issue_ready;
  logic [DATA_W-1:0]    issue_val;

  logic                 alu_result;
  logic [ROB_POS_W-1:0] alu_rob_pos;
  logic [DATA_W-1:0]    alu_val;
  logic                 alu_jump;
  logic [DATA_W-1:0]    alu_target;

  logic                 lsb_result;
  logic [ROB_POS_W-1:0] lsb_rob_pos;
  logic [DATA_W-1:0]    lsb_val;

  logic [ROB_POS_W-1:0] query_pos1;
  logic [ROB_POS_W-1:0] query_pos2;
  logic                 query_ready1;
  logic                 query_ready2;
  logic [DATA_W-1:0]    query_val1;
  logic [DATA_W-1:0]    query_val2;

  logic                 commit;
  logic [REG_POS_W-1:0] commit_rd;
  logic [DATA_W-1:0]    commit_val;
  logic [ROB_POS_W-1:0] commit_rob_pos;
  logic                 commit_store;
  logic                 rollback;
  logic [DATA_W-1:0]    jump_pc;

  modport slave (
    output rob_full, rob_nxt_pos,
    input  issue, issue_type, issue_rd, issue_pc, issue_pred_jump, issue_ready, issue_val,
    input  alu_result, alu_rob_pos, alu_val, alu_jump, alu_target,
    input  lsb_result, lsb_rob_pos, lsb_val,
    input  query_pos1, query_pos2,
    output query_ready1, query_ready2, query_val1, query_val2,
    output commit, commit_rd, commit_val, commit_rob_pos, commit_store, rollback, jump_pc
  );

  modport master (
    input  rob_full, rob_nxt_pos,
    output issue, issue_type, issue_rd, issue_pc, issue_pred_jump, issue_ready, issue_val,
    output alu_result, alu_rob_pos, alu_val, alu_jump, alu_target,
    output lsb_result, lsb_rob_pos, lsb_val,
    output query_pos1, query_pos2,
    input  query_ready1, query_ready2, query_val1, query_val2,
    input  commit, commit_rd, commit_val, commit_rob_pos, commit_store, rollback, jump_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags, captures ALU/LSB results,
// retires the head in program order and flushes on a branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  reorder_buffer_if.slave bus
);

  rob_entry_t           entry [ROB_SIZE];
  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  ready;
  logic [ROB_POS_W-1:0] head;
  logic [ROB_POS_W-1:0] tail;
  logic [CNT_W-1:0]     count;

  logic                 commit_q;
  logic [REG_POS_W-1:0] commit_rd_q;
  logic [DATA_W-1:0]    commit_val_q;
  logic [ROB_POS_W-1:0] commit_pos_q;
  logic                 commit_store_q;
  logic                 rollback_q;
  logic [DATA_W-1:0]    jump_pc_q;

  logic       full;
  logic       commit_ok;
  logic       flush;
  logic       issue_ok;
  logic       alu_ok;
  logic       lsb_ok;
  rob_entry_t head_e;
  rob_entry_t new_e;

  // Per-cycle decisions, all taken from the pre-edge state.
  always_comb begin
    full      = (count == CNT_W'(ROB_SIZE));
    head_e    = entry[head];
    commit_ok = busy[head] & ready[head];
    flush     = commit_ok & is_mispredict(head_e);
    issue_ok  = bus.issue & ~full & ~flush;
    alu_ok    = bus.alu_result & busy[bus.alu_rob_pos];
    lsb_ok    = bus.lsb_result & busy[bus.lsb_rob_pos];

    new_e           = '0;
    new_e.kind      = rob_type_e'(bus.issue_type);
    new_e.rd        = bus.issue_rd;
    new_e.val       = bus.issue_val;
    new_e.pc        = bus.issue_pc;
    new_e.pred_jump = bus.issue_pred_jump;
    // A born-ready entry has no pending outcome, so it can never mispredict.
    new_e.real_jump = bus.issue_pred_jump;
  end

  // Payload storage; validity is tracked by busy/ready, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (lsb_ok) begin
        entry[bus.lsb_rob_pos].val <= bus.lsb_val;
      end
      if (alu_ok) begin
        entry[bus.alu_rob_pos].val       <= bus.alu_val;
        entry[bus.alu_rob_pos].real_jump <= bus.alu_jump;
        entry[bus.alu_rob_pos].target    <= bus.alu_target;
      end
      if (issue_ok) begin
        entry[tail] <= new_e;
      end
    end
  end

  // Pointers, flags and registered commit/rollback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      commit_q       <= 1'b0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      commit_pos_q   <= '0;
      commit_store_q <= 1'b0;
      rollback_q     <= 1'b0;
      jump_pc_q      <= '0;
    end else if (rdy) begin
      commit_q       <= commit_ok;
      commit_store_q <= commit_ok & (head_e.kind == ROB_STORE);
      rollback_q     <= flush;
      if (commit_ok) begin
        commit_rd_q  <= (head_e.kind == ROB_STORE) ? '0 : head_e.rd;
        commit_val_q <= head_e.val;
        commit_pos_q <= head;
      end
      if (flush) begin
        jump_pc_q <= redirect_pc(head_e);
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        busy      <= '0;
        ready     <= '0;
      end else begin
        if (lsb_ok) ready[bus.lsb_rob_pos] <= 1'b1;
        if (alu_ok) ready[bus.alu_rob_pos] <= 1'b1;
        if (commit_ok) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
        end
        if (issue_ok) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= bus.issue_ready;
        end
        head  <= head + ROB_POS_W'(commit_ok);
        tail  <= tail + ROB_POS_W'(issue_ok);
        count <= count + CNT_W'(issue_ok) - CNT_W'(commit_ok);
      end
    end
  end

  // Operand lookup with same-cycle bus bypass; ALU wins over LSB, bus wins over storage.
  logic q1_alu, q1_lsb, q2_alu, q2_lsb;
  assign q1_alu = bus.alu_result & (bus.alu_rob_pos == bus.query_pos1);
  assign q1_lsb = bus.lsb_result & (bus.lsb_rob_pos == bus.query_pos1);
  assign q2_alu = bus.alu_result & (bus.alu_rob_pos == bus.query_pos2);
  assign q2_lsb = bus.lsb_result & (bus.lsb_rob_pos == bus.query_pos2);

  assign bus.query_ready1 = q1_alu | q1_lsb | (busy[bus.query_pos1] & ready[bus.query_pos1]);
  assign bus.query_val1   = q1_alu ? bus.alu_val : (q1_lsb ? bus.lsb_val : entry[bus.query_pos1].val);
  assign bus.query_ready2 = q2_alu | q2_lsb | (busy[bus.query_pos2] & ready[bus.query_pos2]);
  assign bus.query_val2   = q2_alu ? bus.alu_val : (q2_lsb ? bus.lsb_val : entry[bus.query_pos2].val);

  assign bus.rob_full       = full;
  assign bus.rob_nxt_pos    = tail;
  assign bus.commit         = commit_q;
  assign bus.commit_rd      = commit_rd_q;
  assign bus.commit_val     = commit_val_q;
  assign bus.commit_rob_pos = commit_pos_q;
  assign bus.commit_store   = commit_store_q;
  assign bus.rollback       = rollback_q;
  assign bus.jump_pc        = jump_pc_q;

endmodule
